round_robin_arbiter8: RTL and testbench
=======================================

ROUND_ROBIN_ARBITER8 -- requirements
Module: round_robin_arbiter8

Interface
REQ-001 The block SHALL have no parameters; width is fixed at 8 requesters.
REQ-002 CLK  input  1  single clock; all state updates on rising edge.
REQ-003 ASYNCRESETN  input  1  reset, asynchronous assertion, active-low.
REQ-004 REQ  input  8  request lines; bit i = requester i wants the resource.
REQ-005 DONE  input  1  holder releases the resource; sampled only in BUSY.
REQ-006 GNT  output  8  registered grant vector; one-hot or all-zero, never multi-hot.
REQ-007 VALID  output  1  registered; high exactly when GNT is nonzero.
REQ-008 PTR  output  3  registered round-robin pointer: highest-priority index for the next arbitration.

Function
REQ-009 The block SHALL implement a two-state FSM: IDLE, BUSY.
REQ-010 IDLE, REQ == 0: stay IDLE; GNT, VALID, PTR unchanged (GNT = 0, VALID = 0).
REQ-011 IDLE, REQ != 0: select the winner as the first set bit searching indices PTR, PTR+1, ..., 7, 0, ..., PTR-1 (mod 8); next edge: GNT = one-hot(winner), VALID = 1, state = BUSY.
REQ-012 Grant latency SHALL be exactly one cycle: REQ sampled at edge n drives GNT after edge n.
REQ-013 BUSY, DONE = 0: GNT, VALID, PTR held, regardless of REQ changes, including the granted requester dropping its REQ bit.
REQ-014 BUSY, DONE = 1: next edge GNT = 0, VALID = 0, PTR = (winner + 1) mod 8, state = IDLE.
REQ-015 Pointer arithmetic SHALL be 3-bit unsigned with natural wrap (winner 7 -> PTR 0).
REQ-016 After release, the block SHALL spend at least one cycle in IDLE (GNT = 0) before the next grant; no back-to-back grants.
REQ-017 DONE in IDLE SHALL be ignored with no state, PTR or output change.
REQ-018 PTR SHALL change only on release (REQ-014), never on grant or while idle.
REQ-019 A requester asserting REQ continuously SHALL be granted within 8 arbitrations (starvation-free).
REQ-020 All outputs SHALL come directly from flops; no combinational path from REQ or DONE to any output.

Reset
REQ-021 While ASYNCRESETN = 0: GNT = 0, VALID = 0, PTR = 0, state = IDLE, immediately and independent of CLK.
REQ-022 Reset asserted during BUSY SHALL drop the grant without PTR update; PTR returns to 0.
REQ-023 First arbitration after reset deassertion SHALL occur at the first rising edge with ASYNCRESETN = 1 and REQ != 0.

Verification
REQ-024 Reset, then REQ = 0x00 for 5 cycles -> GNT = 0x00, VALID = 0, PTR = 0 throughout.
REQ-025 PTR = 0, REQ = 0x24 -> next cycle GNT = 0x04, VALID = 1; DONE pulse -> GNT = 0x00, PTR = 3; next arbitration with REQ = 0x24 -> GNT = 0x20, then after DONE PTR = 6.
REQ-026 Wrap: PTR = 6, REQ = 0x41 -> GNT = 0x40; DONE -> PTR = 7; REQ = 0x41 -> GNT = 0x01; DONE -> PTR = 1.
REQ-027 REQ = 0xFF held, DONE pulsed one cycle after each grant for 16 grants -> GNT sequence 0x01, 0x02, ..., 0x80, 0x01, ... with one zero-GNT cycle between grants; every index granted exactly twice.
REQ-028 BUSY with GNT = 0x08: drop REQ to 0x00 and pulse DONE in a following IDLE cycle -> GNT held at 0x08 until DONE in BUSY, then 0x00; extra DONE in IDLE leaves PTR = 4.
REQ-029 BUSY with GNT = 0x10, PTR = 2: assert ASYNCRESETN = 0 mid-cycle -> GNT = 0x00, VALID = 0, PTR = 0 before the next clock edge.

Source files
------------

// File: rtl/round_robin_arbiter8.sv
// round_robin_arbiter8: 8-way round-robin arbiter holding each grant until the holder signals done
module round_robin_arbiter8 (
  input  logic       CLK,
  input  logic       ASYNCRESETN,
  input  logic [7:0] REQ,
  input  logic       DONE,
  output logic [7:0] GNT,
  output logic       VALID,
  output logic [2:0] PTR
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;
  logic [0:0] state;
  logic [2:0] win;
  logic [2:0] pick;
  logic [7:0] rot;
  // rotate requests so PTR lands on bit 0, then the lowest set bit is the winner offset
  always_comb begin
    rot = 8'({REQ, REQ} >> PTR);
    pick = PTR;
    for (int k = 7; k >= 0; k--)
      if (rot[k]) pick = PTR + 3'(k);
  end
  // grant from IDLE, hold through BUSY, advance pointer past the winner only on release
  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      state <= IDLE;
      GNT   <= '0;
      VALID <= 1'b0;
      PTR   <= '0;
      win   <= '0;
    end else if (state == IDLE && |REQ) begin
      state <= BUSY;
      GNT   <= 8'b1 << pick;
      VALID <= 1'b1;
      win   <= pick;
    end else if (state == BUSY && DONE) begin
      state <= IDLE;
      GNT   <= '0;
      VALID <= 1'b0;
      PTR   <= win + 3'd1;
    end
  end
endmodule

// File: tb/tb_round_robin_arbiter8.sv
// tb_round_robin_arbiter8: scoreboard bench for the 8-way round-robin arbiter
module tb_round_robin_arbiter8;
  typedef struct packed {
    logic [7:0] r;
    logic       d;
    logic [7:0] g;
    logic [2:0] p;
  } step_t;
  logic       clk = 1'b0;
  logic       arst_n = 1'b0;
  logic [7:0] req = '0;
  logic       done = 1'b0;
  logic [7:0] gnt;
  logic       valid;
  logic [2:0] ptr;
  int checks = 0;
  int failures = 0;
  logic [11:0] sb[$];
  logic       m_busy = 1'b0;
  logic [2:0] m_ptr = '0;
  logic [2:0] m_win = '0;
  logic [7:0] m_gnt = '0;
  logic       m_valid = 1'b0;

  round_robin_arbiter8 dut (
    .CLK(clk), .ASYNCRESETN(arst_n), .REQ(req), .DONE(done),
    .GNT(gnt), .VALID(valid), .PTR(ptr)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_busy = 1'b0; m_ptr = '0; m_win = '0; m_gnt = '0; m_valid = 1'b0;
    sb.delete();
  endtask

  // apply one cycle of stimulus, advance the reference model, queue its expectation
  task automatic drive(input logic [7:0] r, input logic d);
    logic [2:0] idx;
    req = r;
    done = d;
    if (!m_busy && r != 8'h00) begin
      idx = m_ptr;
      while (!r[idx]) idx = idx + 3'd1;
      m_win = idx; m_gnt = 8'h01 << idx; m_valid = 1'b1; m_busy = 1'b1;
    end else if (m_busy && d) begin
      m_gnt = '0; m_valid = 1'b0; m_ptr = m_win + 3'd1; m_busy = 1'b0;
    end
    sb.push_back({m_gnt, m_valid, m_ptr});
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [11:0] e;
    @(posedge clk); #1;
    checks++;
    if ({gnt, valid, ptr} !== 12'h000) begin
      failures++;
      $display("FAIL reset_hold got gnt=%h valid=%b ptr=%0d want 00/0/0", gnt, valid, ptr);
    end
    #2 arst_n = 1'b1;
    model_reset();
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      drive(8'h00, 1'b0);
      e = sb.pop_front();
      checks++;
      if ({gnt, valid, ptr} !== e) begin
        failures++;
        $display("FAIL idle_model[%0d] got gnt=%h valid=%b ptr=%0d want %h", i, gnt, valid, ptr, e);
      end
      checks++;
      if ({gnt, valid, ptr} !== 12'h000) begin
        failures++;
        $display("FAIL idle_const[%0d] got gnt=%h valid=%b ptr=%0d want 00/0/0", i, gnt, valid, ptr);
      end
    end
  endtask

  task automatic test_basic();
    step_t t[8];
    logic [11:0] e;
    t = '{{8'h24, 1'b0, 8'h04, 3'd0}, {8'h24, 1'b1, 8'h00, 3'd3},
          {8'h24, 1'b0, 8'h20, 3'd3}, {8'h24, 1'b1, 8'h00, 3'd6},
          {8'h41, 1'b0, 8'h40, 3'd6}, {8'h00, 1'b1, 8'h00, 3'd7},
          {8'h41, 1'b0, 8'h01, 3'd7}, {8'h00, 1'b1, 8'h00, 3'd1}};
    foreach (t[i]) begin
      drive(t[i].r, t[i].d);
      e = sb.pop_front();
      checks++;
      if ({gnt, valid, ptr} !== e) begin
        failures++;
        $display("FAIL basic_model[%0d] got gnt=%h valid=%b ptr=%0d want %h", i, gnt, valid, ptr, e);
      end
      checks++;
      if ({gnt, valid, ptr} !== {t[i].g, |t[i].g, t[i].p}) begin
        failures++;
        $display("FAIL basic_const[%0d] got gnt=%h valid=%b ptr=%0d want gnt=%h ptr=%0d", i, gnt, valid, ptr, t[i].g, t[i].p);
      end
    end
  endtask

  task automatic test_round_robin();
    logic [11:0] e;
    int cnt[8];
    foreach (cnt[k]) cnt[k] = 0;
    arst_n = 1'b0;
    model_reset();
    #2 arst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      drive(8'hFF, 1'b0);
      e = sb.pop_front();
      checks++;
      if ({gnt, valid, ptr} !== e) begin
        failures++;
        $display("FAIL rr_grant_model[%0d] got gnt=%h valid=%b ptr=%0d want %h", i, gnt, valid, ptr, e);
      end
      checks++;
      if (gnt !== 8'h01 << (i % 8) || valid !== 1'b1) begin
        failures++;
        $display("FAIL rr_grant[%0d] got gnt=%h valid=%b want %h", i, gnt, valid, 8'h01 << (i % 8));
      end
      for (int k = 0; k < 8; k++) if (gnt[k] === 1'b1) cnt[k]++;
      drive(8'hFF, 1'b1);
      e = sb.pop_front();
      checks++;
      if ({gnt, valid, ptr} !== e) begin
        failures++;
        $display("FAIL rr_release_model[%0d] got gnt=%h valid=%b ptr=%0d want %h", i, gnt, valid, ptr, e);
      end
      checks++;
      if (gnt !== 8'h00 || valid !== 1'b0 || ptr !== 3'((i + 1) % 8)) begin
        failures++;
        $display("FAIL rr_release[%0d] got gnt=%h valid=%b ptr=%0d want 00/0/%0d", i, gnt, valid, ptr, (i + 1) % 8);
      end
    end
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (cnt[k] != 2) begin
        failures++;
        $display("FAIL rr_count[%0d] got %0d want 2", k, cnt[k]);
      end
    end
  endtask

  task automatic test_hold();
    step_t t[8];
    logic [11:0] e;
    t = '{{8'h08, 1'b0, 8'h08, 3'd0}, {8'h00, 1'b0, 8'h08, 3'd0},
          {8'h00, 1'b0, 8'h08, 3'd0}, {8'h00, 1'b1, 8'h00, 3'd4},
          {8'h00, 1'b1, 8'h00, 3'd4}, {8'h00, 1'b0, 8'h00, 3'd4},
          {8'h02, 1'b0, 8'h02, 3'd4}, {8'h00, 1'b1, 8'h00, 3'd2}};
    foreach (t[i]) begin
      drive(t[i].r, t[i].d);
      e = sb.pop_front();
      checks++;
      if ({gnt, valid, ptr} !== e) begin
        failures++;
        $display("FAIL hold_model[%0d] got gnt=%h valid=%b ptr=%0d want %h", i, gnt, valid, ptr, e);
      end
      checks++;
      if ({gnt, valid, ptr} !== {t[i].g, |t[i].g, t[i].p}) begin
        failures++;
        $display("FAIL hold_const[%0d] got gnt=%h valid=%b ptr=%0d want gnt=%h ptr=%0d", i, gnt, valid, ptr, t[i].g, t[i].p);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [11:0] e;
    drive(8'h10, 1'b0);
    e = sb.pop_front();
    checks++;
    if ({gnt, valid, ptr} !== e || {gnt, valid, ptr} !== {8'h10, 1'b1, 3'd2}) begin
      failures++;
      $display("FAIL async_setup got gnt=%h valid=%b ptr=%0d want 10/1/2 (model %h)", gnt, valid, ptr, e);
    end
    #3 arst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({gnt, valid, ptr} !== 12'h000) begin
      failures++;
      $display("FAIL async_drop got gnt=%h valid=%b ptr=%0d want 00/0/0", gnt, valid, ptr);
    end
    #2 arst_n = 1'b1;
    drive(8'h10, 1'b0);
    e = sb.pop_front();
    checks++;
    if ({gnt, valid, ptr} !== e || {gnt, valid, ptr} !== {8'h10, 1'b1, 3'd0}) begin
      failures++;
      $display("FAIL async_first_grant got gnt=%h valid=%b ptr=%0d want 10/1/0 (model %h)", gnt, valid, ptr, e);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_round_robin();
    test_hold();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
